lsq_mem_port: RTL

Parametrised load/store request queue between the load/store buffer and the byte-wide RAM/IO port. Accepts tagged byte/half/word requests into a FIFO of configurable depth and serialises each into little-endian single-byte memory cycles. Loads return a sign- or zero-extended 32-bit result with their tag. Supports selective flush: `clear_in` kills queued and in-flight loads, while committed stores always complete.

---
 rtl/lsq_mem_port.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/lsq_mem_port.sv
// Load/store request FIFO feeding a byte-wide memory port; loads return extended data with their tag.
// Optional LSQ_STATS_EN adds completed-load/store and killed-load counters.
module lsq_mem_port #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_data,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    output logic             busy
`ifdef LSQ_STATS_EN
    ,
    output logic [31:0]      stat_loads,
    output logic [31:0]      stat_stores,
    output logic [31:0]      stat_killed
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STORE  = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_LDWAIT = 2'd3;

    typedef struct packed {
        logic             wr;
        logic [1:0]       size;
        logic             sgn;
        logic [TAG_W-1:0] tag;
        logic [31:0]      addr;
        logic [31:0]      wdata;
    } req_t;

    req_t             r_q [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_cnt;
    logic [1:0]       r_state;
    req_t             r_cur;
    logic [1:0]       r_k;
    logic [31:0]      r_ld;
    logic             r_done;
    logic             r_resp_valid;
    logic [TAG_W-1:0] r_resp_tag;
    logic [31:0]      r_resp_data;
    logic [31:0]      r_mem_a;
    logic [7:0]       r_mem_dout;
    logic             r_mem_wr;

    logic        w_push, w_pop, w_head_live, w_last;
    logic [1:0]  w_nm1;
    logic [31:0] w_ext;
    req_t        w_req, w_head;

    assign req_ready = (r_cnt < (AW+1)'(DEPTH)) && rdy_in;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = rdy_in && (r_state == S_IDLE) && (r_cnt != '0);
    assign w_req     = '{wr: req_wr, size: req_size, sgn: req_signed, tag: req_tag,
                         addr: req_addr, wdata: req_wdata};
    assign w_head    = r_q[r_rp];
    // A load being popped in the same cycle as a flush is already dead.
    assign w_head_live = r_live[r_rp] && !(clear_in && !w_head.wr);
    assign w_nm1     = (r_cur.size == 2'b00) ? 2'd0 : (r_cur.size == 2'b01) ? 2'd1 : 2'd3;
    assign w_last    = (r_k == w_nm1);

    always_comb begin
        w_ext = r_ld;
        case (r_cur.size)
            2'b00:   w_ext = {{24{r_cur.sgn & r_ld[7]}}, r_ld[7:0]};
            2'b01:   w_ext = {{16{r_cur.sgn & r_ld[15]}}, r_ld[15:0]};
            default: w_ext = r_ld;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_q[r_wp] <= w_req;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            r_live       <= '0;
            r_state      <= S_IDLE;
            r_cur        <= '0;
            r_k          <= '0;
            r_ld         <= '0;
            r_done       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_tag   <= '0;
            r_resp_data  <= '0;
            r_mem_a      <= '0;
            r_mem_dout   <= '0;
            r_mem_wr     <= 1'b0;
        end else if (rdy_in) begin
            r_mem_wr     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_done       <= 1'b0;
            if (r_done) begin
                r_resp_valid <= 1'b1;
                r_resp_tag   <= r_cur.tag;
                r_resp_data  <= w_ext;
            end

            if (clear_in) begin
                for (int i = 0; i < DEPTH; i++)
                    if (!r_q[i].wr) r_live[i] <= 1'b0;
            end
            if (w_pop) begin
                r_live[r_rp] <= 1'b0;
                r_rp         <= r_rp + 1'b1;
            end
            // Push after the flush loop so a same-cycle request stays live.
            if (w_push) begin
                r_live[r_wp] <= 1'b1;
                r_wp         <= r_wp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur <= w_head;
                        r_k   <= 2'd0;
                        r_ld  <= '0;
                        if (w_head_live) r_state <= w_head.wr ? S_STORE : S_LOAD;
                    end
                end
                S_STORE: begin
                    r_mem_a    <= r_cur.addr + 32'(r_k);
                    r_mem_dout <= r_cur.wdata[{r_k, 3'b000} +: 8];
                    r_mem_wr   <= 1'b1;
                    r_k        <= r_k + 1'b1;
                    if (w_last) r_state <= S_IDLE;
                end
                S_LOAD: begin
                    if (clear_in) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_mem_a <= r_cur.addr + 32'(r_k);
                        if (r_k != 2'd0) r_ld[{r_k - 2'd1, 3'b000} +: 8] <= mem_din;
                        r_k <= r_k + 1'b1;
                        if (w_last) r_state <= S_LDWAIT;
                    end
                end
                default: begin
                    if (!clear_in) begin
                        r_ld[{w_nm1, 3'b000} +: 8] <= mem_din;
                        r_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid && rdy_in;
    assign resp_tag   = r_resp_tag;
    assign resp_data  = r_resp_data;
    assign mem_a      = r_mem_a;
    assign mem_dout   = r_mem_dout;
    assign mem_wr     = r_mem_wr && rdy_in;
    assign busy       = (r_cnt != '0) || (r_state != S_IDLE);

`ifdef LSQ_STATS_EN
    logic [31:0] r_stat_loads, r_stat_stores, r_stat_killed;
    logic [31:0] w_kill_q;
    logic        w_kill_f;

    // Queued live loads wiped by this flush, plus the one in flight.
    always_comb begin
        w_kill_q = '0;
        for (int i = 0; i < DEPTH; i++)
            w_kill_q = w_kill_q + 32'(r_live[i] & ~r_q[i].wr);
        if (!clear_in) w_kill_q = '0;
    end
    assign w_kill_f = clear_in && ((r_state == S_LOAD) || (r_state == S_LDWAIT));

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_stat_loads  <= '0;
            r_stat_stores <= '0;
            r_stat_killed <= '0;
        end else if (rdy_in) begin
            if (r_done) r_stat_loads <= r_stat_loads + 32'd1;
            if ((r_state == S_STORE) && w_last) r_stat_stores <= r_stat_stores + 32'd1;
            r_stat_killed <= r_stat_killed + w_kill_q + 32'(w_kill_f);
        end
    end

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_killed = r_stat_killed;
`endif
endmodule
